// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types, constants and op decode helpers for the M-extension sequencer
package muldiv_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_t;
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;
  localparam logic [31:0] INT_MIN   = 32'h80000000;
  function automatic logic is_div(op_t o);
    return o[2];
  endfunction
  function automatic logic op_signed_a(op_t o);
    return o inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction
  function automatic logic op_signed_b(op_t o);
    return o inside {OP_MULH, OP_DIV, OP_REM};
  endfunction
endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: final sign correction and result selection from the magnitude accumulator
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  op_t               op,
  input  logic              sa,
  input  logic              sb,
  input  logic              dz,
  input  logic [2*XLEN-1:0] acc,
  output logic [XLEN-1:0]   result
);
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quot, rem;
  always_comb begin
    prod = (sa ^ sb) ? -acc : acc;
    quot = (sa ^ sb && !dz) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    result = !is_div(op) ? (op == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) :
             op[1] ? rem : quot;
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative radix-2 RV32M multiply/divide sequencer with stall handshake
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  state_t state, state_nx;
  op_t op_in, op_q;
  logic sa, sb, dz, sa_in, sb_in, dz_in, ovf_in, special, accept;
  logic [XLEN-1:0] a_mag, b_mag, opnd, res_fix;
  logic [2*XLEN-1:0] acc, acc_nx;
  logic [XLEN:0] mul_sum;
  logic [XLEN+1:0] div_diff;
  logic [CW-1:0] cnt;
  always_comb begin
    op_in = op_t'(op);
    sa_in = op_signed_a(op_in) && rs1[XLEN-1];
    sb_in = op_signed_b(op_in) && rs2[XLEN-1];
    a_mag = sa_in ? -rs1 : rs1;
    b_mag = sb_in ? -rs2 : rs2;
    dz_in = is_div(op_in) && rs2 == '0;
    ovf_in = (op_in == OP_DIV || op_in == OP_REM) && rs1 == INT_MIN && rs2 == '1;
    special = EARLY_OUT && (dz_in || ovf_in);
    accept = start && !flush && state == IDLE;
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_diff = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b0, opnd};
    acc_nx = !is_div(op_q) ? {mul_sum, acc[XLEN-1:1]} :
             div_diff[XLEN+1] ? {acc[2*XLEN-2:0], 1'b0} :
             {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = flush ? IDLE :
               state == IDLE ? (start ? (special ? FIN : CALC) : IDLE) :
               state == CALC ? (cnt == '0 ? FIN : CALC) : IDLE;
  always_comb busy = state != IDLE;
  // Early-out cases preload the accumulator so the common sign-fix path yields the RV32M result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q <= OP_MUL;
      sa <= 1'b0;
      sb <= 1'b0;
      dz <= 1'b0;
      opnd <= '0;
      acc <= '0;
      cnt <= '0;
      done <= 1'b0;
      result <= '0;
    end else begin
      done <= state == FIN && !flush;
      if (state == FIN && !flush) result <= res_fix;
      if (accept) begin
        op_q <= op_in;
        sa <= sa_in;
        sb <= sb_in;
        dz <= dz_in;
        cnt <= CW'(XLEN - 1);
        opnd <= is_div(op_in) ? b_mag : a_mag;
        acc <= !special ? {{XLEN{1'b0}}, is_div(op_in) ? a_mag : b_mag} :
               dz_in ? {a_mag, DIV0_QUOT} : {{XLEN{1'b0}}, INT_MIN};
      end else if (state == CALC) begin
        acc <= acc_nx;
        cnt <= cnt - 1'b1;
      end
    end
  end
  muldiv_signfix #(.XLEN(XLEN)) u_fix (
    .op(op_q),
    .sa(sa),
    .sb(sb),
    .dz(dz),
    .acc(acc),
    .result(res_fix)
  );
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed checks of the multiply/divide sequencer with and without early-out
module tb_muldiv_seq;
  logic clk = 1'b0, rst_n = 1'b0, start1 = 1'b0, start0 = 1'b0, flush = 1'b0;
  logic [2:0] op = 3'b000;
  logic [31:0] rs1 = '0, rs2 = '0, result1, result0;
  logic busy1, done1, busy0, done0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32), .EARLY_OUT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .busy(busy1), .done(done1), .result(result1)
  );
  muldiv_seq #(.XLEN(32), .EARLY_OUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .busy(busy0), .done(done0), .result(result0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit e0, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; rs1 = x; rs2 = y;
    if (e0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0; start1 = 1'b0;
    rs1 = $urandom; rs2 = $urandom;
  endtask

  task automatic wait_done(input bit e0, input int lat, input logic [31:0] exp, input string tag, input bit tail);
    int n = 0;
    bit d = 1'b0;
    while (!d && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      d = e0 ? done0 : done1;
    end
    chk({tag, " latency"}, 32'(n), 32'(lat));
    chk({tag, " result"}, e0 ? result0 : result1, exp);
    chk({tag, " busy at done"}, 32'(e0 ? busy0 : busy1), 32'd0);
    if (tail) begin
      @(posedge clk);
      #1;
      chk({tag, " done pulse width"}, 32'(e0 ? done0 : done1), 32'd0);
    end
  endtask

  task automatic no_done(input int cycles, input string tag);
    int c = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (done1) c++;
    end
    chk(tag, 32'(c), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy1), 32'd0);
    chk("reset done", 32'(done1), 32'd0);
    chk("reset result", result1, 32'd0);
    chk("reset busy eo0", 32'(busy0), 32'd0);
    rst_n = 1'b1;

    issue(0, 3'b000, 32'd7, 32'hFFFFFFFD);
    chk("mul busy after accept", 32'(busy1), 32'd1);
    wait_done(0, 33, 32'hFFFFFFEB, "mul 7*-3", 1);
    issue(0, 3'b001, 32'h80000000, 32'h80000000);
    wait_done(0, 33, 32'h40000000, "mulh min*min", 1);
    issue(0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(0, 33, 32'hFFFFFFFE, "mulhu max*max", 1);
    issue(0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(0, 33, 32'hFFFFFFFF, "mulhsu -1*max", 1);
    issue(0, 3'b100, 32'hFFFFFFF9, 32'd2);
    wait_done(0, 33, 32'hFFFFFFFD, "div -7/2", 1);
    issue(0, 3'b110, 32'hFFFFFFF9, 32'd2);
    wait_done(0, 33, 32'hFFFFFFFF, "rem -7%2", 1);
    issue(0, 3'b101, 32'd100, 32'd7);
    wait_done(0, 33, 32'd14, "divu 100/7", 1);
    issue(0, 3'b111, 32'd100, 32'd7);
    wait_done(0, 33, 32'd2, "remu 100%7", 1);

    issue(0, 3'b100, 32'hFFFFFFF9, 32'd0);
    wait_done(0, 1, 32'hFFFFFFFF, "eo div by 0", 1);
    issue(0, 3'b110, 32'd5, 32'd0);
    wait_done(0, 1, 32'd5, "eo rem by 0", 1);
    issue(0, 3'b101, 32'd9, 32'd0);
    wait_done(0, 1, 32'hFFFFFFFF, "eo divu by 0", 1);
    issue(0, 3'b111, 32'd9, 32'd0);
    wait_done(0, 1, 32'd9, "eo remu by 0", 1);
    issue(0, 3'b100, 32'h80000000, 32'hFFFFFFFF);
    wait_done(0, 1, 32'h80000000, "eo div ovf", 1);
    issue(0, 3'b110, 32'h80000000, 32'hFFFFFFFF);
    wait_done(0, 1, 32'd0, "eo rem ovf", 1);

    issue(1, 3'b100, 32'hFFFFFFF9, 32'd0);
    wait_done(1, 33, 32'hFFFFFFFF, "noeo div by 0", 1);
    issue(1, 3'b110, 32'd5, 32'd0);
    wait_done(1, 33, 32'd5, "noeo rem by 0", 1);
    issue(1, 3'b100, 32'h80000000, 32'hFFFFFFFF);
    wait_done(1, 33, 32'h80000000, "noeo div ovf", 1);
    issue(1, 3'b110, 32'h80000000, 32'hFFFFFFFF);
    wait_done(1, 33, 32'd0, "noeo rem ovf", 1);

    issue(0, 3'b000, 32'd3, 32'd5);
    wait_done(0, 33, 32'd15, "mul 3*5", 1);
    issue(0, 3'b100, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush busy", 32'(busy1), 32'd0);
    chk("flush done", 32'(done1), 32'd0);
    no_done(40, "flush no done");
    chk("flush result kept", result1, 32'd15);
    issue(0, 3'b000, 32'd3, 32'd4);
    wait_done(0, 33, 32'd12, "mul 3*4 after flush", 1);

    issue(0, 3'b000, 32'd6, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start1 = 1'b1; op = 3'b000; rs1 = 32'd2; rs2 = 32'd2;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    wait_done(0, 28, 32'd42, "mul 6*7 start ignored", 1);
    no_done(40, "busy start no extra done");

    issue(0, 3'b101, 32'd1000, 32'd10);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midop reset busy", 32'(busy1), 32'd0);
    chk("midop reset done", 32'(done1), 32'd0);
    chk("midop reset result", result1, 32'd0);
    rst_n = 1'b1;
    no_done(40, "midop reset no done");

    issue(0, 3'b101, 32'hFFFFFFFF, 32'h10);
    wait_done(0, 33, 32'h0FFFFFFF, "b2b first divu", 0);
    issue(0, 3'b110, 32'hFFFFFFF9, 32'hFFFFFFFE);
    chk("b2b accepted in done cycle", 32'(busy1), 32'd1);
    wait_done(0, 33, 32'hFFFFFFFF, "b2b second rem", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
